apuf_eval_ctrl: RTL and testbench
=================================

APUF_EVAL_CTRL -- requirements
Module: apuf_eval_ctrl

Interface
REQ-001 SHALL have parameter nStage, default 16, challenge width (number of switch stages driven).
REQ-002 SHALL have parameter SETTLE, default 8, settle cycles per phase; legal range 1..255.
REQ-003 SHALL have parameter NREP, default 7, evaluations per challenge; odd, 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port chal_in  input  nStage  challenge to evaluate.
REQ-007 SHALL have port chal_valid  input  1  challenge offered.
REQ-008 SHALL have port chal_ready  output  1  block can accept a challenge.
REQ-009 SHALL have port c  output  nStage  registered challenge driven to the switch chain.
REQ-010 SHALL have port trig  output  1  registered trigger driven to both chain inputs (top and bottom).
REQ-011 SHALL have port arb_bit  input  1  asynchronous arbiter latch output fed by the chain's top/bottom outputs.
REQ-012 SHALL have port resp  output  1  majority-voted response bit.
REQ-013 SHALL have port ones_cnt  output  4  count of evaluations that sampled 1.
REQ-014 SHALL have port resp_valid  output  1  resp/ones_cnt valid.
REQ-015 SHALL have port resp_ready  input  1  consumer accepts response.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FIRE, RELAX, DONE.
REQ-017 SHALL assert chal_ready only in IDLE; transfer = chal_valid && chal_ready at a rising edge.
REQ-018 On transfer SHALL register chal_in into c, clear ones_cnt and the repetition counter, and enter LOAD.
REQ-019 SHALL hold c constant from transfer until the next transfer; c changes only on a transfer.
REQ-020 LOAD SHALL last SETTLE cycles with trig=0, then enter FIRE.
REQ-021 FIRE SHALL last SETTLE+2 cycles with trig=1.
REQ-022 SHALL pass arb_bit through a 2-flop synchronizer; the synchronized value sampled in FIRE's last cycle SHALL increment ones_cnt when 1.
REQ-023 After FIRE, RELAX SHALL last SETTLE cycles with trig=0.
REQ-024 At RELAX end: fewer than NREP evaluations done -> FIRE; otherwise -> DONE.
REQ-025 Acceptance-to-resp_valid latency SHALL be exactly SETTLE + NREP*(2*SETTLE+2) cycles.
REQ-026 In DONE SHALL assert resp_valid with resp = (ones_cnt > NREP/2) and ones_cnt stable.
REQ-027 resp_valid && resp_ready at an edge SHALL return the block to IDLE; a new challenge is accepted no earlier than the following edge.
REQ-028 resp_ready outside DONE SHALL be ignored; chal_valid outside IDLE SHALL be ignored (chal_ready=0).
REQ-029 Phase timer SHALL be 8 bits and reload at every state entry; no wrap-around within a phase.
REQ-030 ones_cnt SHALL saturate at NREP (never exceeds NREP).

Reset
REQ-031 rst_n low SHALL immediately force IDLE, c=0, trig=0, resp=0, ones_cnt=0, resp_valid=0, chal_ready=1 after release, synchronizer flops=0.
REQ-032 Reset asserted mid-evaluation SHALL abort it; the in-flight result is discarded and never presented.

Verification
REQ-033 SETTLE=4, NREP=3, chal_in=16'hA5C3, arb_bit=1 constant -> c=16'hA5C3, three trig pulses 6 cycles high, resp_valid exactly 34 cycles after acceptance, resp=1, ones_cnt=3.
REQ-034 Same setup, arb_bit=1 in evaluations 1 and 3 only, 0 in 2 -> resp=1, ones_cnt=2; then arb_bit=1 only in evaluation 2 -> resp=0, ones_cnt=1.
REQ-035 resp_ready held low 20 cycles in DONE -> resp_valid, resp, ones_cnt stable all 20 cycles; chal_valid pulsed meanwhile -> ignored, c unchanged.
REQ-036 rst_n pulsed low during second FIRE -> trig=0 and resp_valid=0 immediately; after release chal_ready=1, next challenge completes with full latency 34.
REQ-037 Back-to-back: chal_valid held high with resp_ready=1 -> second challenge accepted one cycle after response handshake, no lost or duplicated response.
REQ-038 SETTLE=1, NREP=1, arb_bit=0 -> resp_valid 5 cycles after acceptance, resp=0, ones_cnt=0.

Source files
------------

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: loads a challenge, fires the chain NREP times,
// counts arbiter ones through a synchronizer and presents the majority-voted response.
module apuf_eval_ctrl #(
    parameter int nStage = 16,
    parameter int SETTLE = 8,
    parameter int NREP   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [nStage-1:0] chal_in,
    input  logic              chal_valid,
    output logic              chal_ready,
    output logic [nStage-1:0] c,
    output logic              trig,
    input  logic              arb_bit,
    output logic              resp,
    output logic [3:0]        ones_cnt,
    output logic              resp_valid,
    input  logic              resp_ready
);
    // state | meaning
    // IDLE  | waiting for a challenge, chal_ready=1
    // LOAD  | challenge applied, chain settling, trig=0
    // FIRE  | trig=1, arbiter resolving; sample taken in last cycle
    // RELAX | trig=0, chain returning to rest before next repetition
    // DONE  | resp/ones_cnt presented until resp_ready
    typedef enum logic [2:0] {IDLE, LOAD, FIRE, RELAX, DONE} state_t;

    localparam logic [7:0] T_PHASE = 8'(SETTLE - 1);
    localparam logic [7:0] T_FIRE  = 8'(SETTLE);
    localparam logic [3:0] N_REP   = 4'(NREP);
    localparam logic [3:0] N_HALF  = 4'(NREP / 2);

    state_t     state;
    logic [7:0] timer;
    logic       fire_tail;
    logic [3:0] rep_cnt;
    logic       sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= arb_bit;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= 8'd0;
            fire_tail  <= 1'b0;
            rep_cnt    <= 4'd0;
            c          <= '0;
            trig       <= 1'b0;
            resp       <= 1'b0;
            ones_cnt   <= 4'd0;
            resp_valid <= 1'b0;
            chal_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (chal_valid) begin
                        c          <= chal_in;
                        ones_cnt   <= 4'd0;
                        rep_cnt    <= 4'd0;
                        timer      <= T_PHASE;
                        chal_ready <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (timer == 8'd0) begin
                        trig      <= 1'b1;
                        timer     <= T_FIRE;
                        fire_tail <= 1'b0;
                        state     <= FIRE;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                FIRE: begin
                    // SETTLE+2 cycles: count SETTLE..0, then one tail cycle so the
                    // 8-bit timer never needs to hold SETTLE+1.
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else if (!fire_tail) begin
                        fire_tail <= 1'b1;
                    end else begin
                        if (sync2 && (ones_cnt < N_REP))
                            ones_cnt <= ones_cnt + 4'd1;
                        rep_cnt   <= rep_cnt + 4'd1;
                        trig      <= 1'b0;
                        fire_tail <= 1'b0;
                        timer     <= T_PHASE;
                        state     <= RELAX;
                    end
                end
                RELAX: begin
                    if (timer == 8'd0) begin
                        if (rep_cnt < N_REP) begin
                            trig      <= 1'b1;
                            timer     <= T_FIRE;
                            fire_tail <= 1'b0;
                            state     <= FIRE;
                        end else begin
                            resp       <= (ones_cnt > N_HALF);
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        chal_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench for apuf_eval_ctrl: main instance SETTLE=4/NREP=3, corner instance SETTLE=1/NREP=1.
module tb_apuf_eval_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] chal_in;
    logic        chal_valid;
    logic        chal_ready;
    logic [15:0] c;
    logic        trig;
    logic        arb_bit;
    logic        resp;
    logic [3:0]  ones_cnt;
    logic        resp_valid;
    logic        resp_ready;

    logic [15:0] chal_in2;
    logic        chal_valid2;
    logic        chal_ready2;
    logic [15:0] c2;
    logic        trig2;
    logic        arb_bit2;
    logic        resp2;
    logic [3:0]  ones_cnt2;
    logic        resp_valid2;
    logic        resp_ready2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    apuf_eval_ctrl #(.nStage(16), .SETTLE(4), .NREP(3)) dut (
        .clk(clk), .rst_n(rst_n), .chal_in(chal_in), .chal_valid(chal_valid),
        .chal_ready(chal_ready), .c(c), .trig(trig), .arb_bit(arb_bit),
        .resp(resp), .ones_cnt(ones_cnt), .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

    apuf_eval_ctrl #(.nStage(16), .SETTLE(1), .NREP(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .chal_in(chal_in2), .chal_valid(chal_valid2),
        .chal_ready(chal_ready2), .c(c2), .trig(trig2), .arb_bit(arb_bit2),
        .resp(resp2), .ones_cnt(ones_cnt2), .resp_valid(resp_valid2), .resp_ready(resp_ready2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Offer one challenge, drive arb_bit per repetition from pat, return timing stats.
    task automatic run_eval(input logic [15:0] ch, input logic [2:0] pat,
                            output int lat, output int pulses, output int wmin, output int wmax);
        int cnt;
        int cur_w;
        logic prev;
        @(negedge clk);
        chal_in    = ch;
        chal_valid = 1'b1;
        arb_bit    = pat[0];
        @(posedge clk);
        #1 chal_valid = 1'b0;
        cnt = 0; cur_w = 0; prev = 1'b0; pulses = 0; wmin = 999; wmax = 0; lat = -1;
        while (cnt < 200) begin
            @(posedge clk);
            #1 cnt++;
            if (trig) cur_w++;
            if (prev && !trig) begin
                pulses++;
                if (cur_w < wmin) wmin = cur_w;
                if (cur_w > wmax) wmax = cur_w;
                cur_w = 0;
                if (pulses < 3) arb_bit = pat[pulses];
            end
            prev = trig;
            if (resp_valid) begin
                lat = cnt;
                break;
            end
        end
        if (lat < 0) chk("eval_timeout", 32'(cnt), 32'd0);
    endtask

    task automatic handshake_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_valid_low", 32'(resp_valid), 32'd0);
        chk("hs_ready_high", 32'(chal_ready), 32'd1);
        resp_ready = 1'b0;
    endtask

    int lat, pulses, wmin, wmax;

    initial begin
        rst_n = 1'b0;
        chal_in = '0; chal_valid = 1'b0; arb_bit = 1'b0; resp_ready = 1'b0;
        chal_in2 = '0; chal_valid2 = 1'b0; arb_bit2 = 1'b0; resp_ready2 = 1'b0;
        #12;
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_resp", 32'(resp), 32'd0);
        chk("rst_ones", 32'(ones_cnt), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_ready", 32'(chal_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All ones
        run_eval(16'hA5C3, 3'b111, lat, pulses, wmin, wmax);
        chk("a_lat", 32'(lat), 32'd34);
        chk("a_c", 32'(c), 32'hA5C3);
        chk("a_pulses", 32'(pulses), 32'd3);
        chk("a_wmin", 32'(wmin), 32'd6);
        chk("a_wmax", 32'(wmax), 32'd6);
        chk("a_resp", 32'(resp), 32'd1);
        chk("a_ones", 32'(ones_cnt), 32'd3);

        // Hold resp_ready low 20 cycles; stray chal_valid must be ignored
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chal_valid = (i == 5);
            chal_in    = 16'h1111;
            chk("hold_ready", 32'(chal_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_resp", 32'(resp), 32'd1);
            chk("hold_ones", 32'(ones_cnt), 32'd3);
            chk("hold_c", 32'(c), 32'hA5C3);
        end
        chal_valid = 1'b0;
        handshake_resp();

        // Majority 2 of 3
        run_eval(16'h0F0F, 3'b101, lat, pulses, wmin, wmax);
        chk("b_lat", 32'(lat), 32'd34);
        chk("b_resp", 32'(resp), 32'd1);
        chk("b_ones", 32'(ones_cnt), 32'd2);
        handshake_resp();

        // Minority 1 of 3
        run_eval(16'h3C3C, 3'b010, lat, pulses, wmin, wmax);
        chk("c_lat", 32'(lat), 32'd34);
        chk("c_resp", 32'(resp), 32'd0);
        chk("c_ones", 32'(ones_cnt), 32'd1);
        chk("c_c", 32'(c), 32'h3C3C);
        handshake_resp();

        // Reset during second FIRE
        begin
            int rises, cnt;
            logic prev;
            @(negedge clk);
            chal_in = 16'hBEEF; chal_valid = 1'b1; arb_bit = 1'b1;
            @(posedge clk);
            #1 chal_valid = 1'b0;
            rises = 0; cnt = 0; prev = 1'b0;
            while (cnt < 100 && rises < 2) begin
                @(posedge clk);
                #1 cnt++;
                if (trig && !prev) rises++;
                prev = trig;
            end
            chk("r_second_fire", 32'(trig), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            chk("r_trig", 32'(trig), 32'd0);
            chk("r_valid", 32'(resp_valid), 32'd0);
            chk("r_c", 32'(c), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1 chk("r_ready", 32'(chal_ready), 32'd1);
            chk("r_ones", 32'(ones_cnt), 32'd0);
        end
        run_eval(16'h1234, 3'b111, lat, pulses, wmin, wmax);
        chk("r2_lat", 32'(lat), 32'd34);
        chk("r2_ones", 32'(ones_cnt), 32'd3);
        chk("r2_c", 32'(c), 32'h1234);
        handshake_resp();

        // Back-to-back with chal_valid held high
        begin
            int e, n_acc, n_hs, a1, a2, h1, h2;
            logic [15:0] c_after2;
            e = 0; n_acc = 0; n_hs = 0; a1 = 0; a2 = 0; h1 = 0; h2 = 0; c_after2 = '0;
            @(negedge clk);
            resp_ready = 1'b1; arb_bit = 1'b1;
            chal_in = 16'hCAFE; chal_valid = 1'b1;
            while (e < 200 && n_hs < 2) begin
                if (chal_valid && chal_ready) begin
                    n_acc++;
                    if (n_acc == 1) a1 = e + 1; else a2 = e + 1;
                end
                if (resp_valid && resp_ready) begin
                    n_hs++;
                    chk("bb_resp", 32'(resp), 32'd1);
                    if (n_hs == 1) h1 = e + 1;
                    else begin h2 = e + 1; chal_valid = 1'b0; end
                end
                @(posedge clk);
                e++;
                #1;
                if (n_acc == 1) chal_in = 16'hD00D;
                if (n_acc == 2 && a2 == e) c_after2 = c;
                @(negedge clk);
            end
            chk("bb_acc", 32'(n_acc), 32'd2);
            chk("bb_hs", 32'(n_hs), 32'd2);
            chk("bb_h1", 32'(h1 - a1), 32'd35);
            chk("bb_a2", 32'(a2 - h1), 32'd1);
            chk("bb_h2", 32'(h2 - a2), 32'd35);
            chk("bb_c2", 32'(c_after2), 32'hD00D);
            @(posedge clk);
            #1 chk("bb_idle", 32'(chal_ready), 32'd1);
            resp_ready = 1'b0;
        end

        // Minimum configuration instance
        begin
            int cnt;
            @(negedge clk);
            chal_in2 = 16'h8001; chal_valid2 = 1'b1; arb_bit2 = 1'b0;
            @(posedge clk);
            #1 chal_valid2 = 1'b0;
            cnt = 0;
            while (cnt < 50 && !resp_valid2) begin
                @(posedge clk);
                #1 cnt++;
            end
            chk("m_lat", 32'(cnt), 32'd5);
            chk("m_resp", 32'(resp2), 32'd0);
            chk("m_ones", 32'(ones_cnt2), 32'd0);
            chk("m_c", 32'(c2), 32'h8001);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
